// File: rtl/uart_txrx_pkg.sv
// Shared frame constants and FSM state encoding for the 8N1 UART transmitter and receiver.
package uart_txrx_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned IDX_W       = $clog2(DATA_BITS);
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs while not cleared and wraps to zero on the last cycle of a bit,
// or of half a bit when i_Half is set (used to find mid-bit after a start edge).
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Half,
    output logic o_Wrap_c
);

    localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

    logic [CNT_W-1:0] r_count;

    assign o_Wrap_c = (r_count == (i_Half ? HALF_LAST : FULL_LAST));

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear || o_Wrap_c) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmit and receive FSMs, each with its own bit timer.
module uart_txrx
    import uart_txrx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_e          r_tx_state;
    logic [DATA_BITS-1:0] r_tx_data;
    logic [IDX_W-1:0]     r_tx_idx;
    logic                 r_tx_serial;
    logic                 r_tx_active;
    logic                 r_tx_done;
    logic                 w_tx_clear;
    logic                 w_tx_wrap;
    logic [IDX_W-1:0]     w_tx_next_idx;

    assign w_tx_clear    = (r_tx_state == S_IDLE) || (r_tx_state == S_CLEANUP);
    assign w_tx_next_idx = r_tx_idx + IDX_W'(1);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_timer (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Clear  (w_tx_clear),
        .i_Half   (1'b0),
        .o_Wrap_c (w_tx_wrap)
    );

    // Line level is registered one bit ahead so each bit appears on the cycle after its timer wrap.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_tx_state  <= S_IDLE;
            r_tx_data   <= '0;
            r_tx_idx    <= '0;
            r_tx_serial <= STOP_LEVEL;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_tx_state)
                S_IDLE: begin
                    r_tx_serial <= STOP_LEVEL;
                    r_tx_active <= 1'b0;
                    r_tx_idx    <= '0;
                    if (i_Tx_DV) begin
                        r_tx_data   <= i_Tx_Byte;
                        r_tx_serial <= START_LEVEL;
                        r_tx_active <= 1'b1;
                        r_tx_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_wrap) begin
                        r_tx_serial <= r_tx_data[0];
                        r_tx_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tx_wrap) begin
                        if (r_tx_idx == IDX_LAST) begin
                            r_tx_serial <= STOP_LEVEL;
                            r_tx_state  <= S_STOP;
                        end else begin
                            r_tx_idx    <= w_tx_next_idx;
                            r_tx_serial <= r_tx_data[w_tx_next_idx];
                        end
                    end
                end
                S_STOP: begin
                    if (w_tx_wrap) begin
                        r_tx_done   <= 1'b1;
                        r_tx_active <= 1'b0;
                        r_tx_state  <= S_CLEANUP;
                    end
                end
                S_CLEANUP: begin
                    r_tx_state <= S_IDLE;
                end
                default: begin
                    r_tx_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Serial = r_tx_serial;
    assign o_Tx_Active = r_tx_active;
    assign o_Tx_Done   = r_tx_done;

    // ---------------- receiver ----------------
    logic                 r_rx_sync1;
    logic                 r_rx_sync2;
    uart_state_e          r_rx_state;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [DATA_BITS-1:0] r_rx_byte;
    logic [IDX_W-1:0]     r_rx_idx;
    logic                 r_rx_dv;
    logic                 w_rx_clear;
    logic                 w_rx_half;
    logic                 w_rx_wrap;

    assign w_rx_clear = (r_rx_state == S_IDLE) || (r_rx_state == S_CLEANUP);
    assign w_rx_half  = (r_rx_state == S_START);

    // Two-flop synchronizer; the raw pin is never used elsewhere.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rx_sync1 <= STOP_LEVEL;
            r_rx_sync2 <= STOP_LEVEL;
        end else begin
            r_rx_sync1 <= i_Rx_Serial;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_timer (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Clear  (w_rx_clear),
        .i_Half   (w_rx_half),
        .o_Wrap_c (w_rx_wrap)
    );

    // Half-bit wrap in START aligns all later full-bit wraps to mid-bit sample points.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rx_state <= S_IDLE;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_idx   <= '0;
            r_rx_dv    <= 1'b0;
        end else begin
            r_rx_dv <= 1'b0;
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_idx <= '0;
                    if (r_rx_sync2 == START_LEVEL) begin
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_rx_wrap) begin
                        r_rx_state <= (r_rx_sync2 == START_LEVEL) ? S_DATA : S_IDLE;
                    end
                end
                S_DATA: begin
                    if (w_rx_wrap) begin
                        r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == IDX_LAST) begin
                            r_rx_state <= S_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + IDX_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (w_rx_wrap) begin
                        if (r_rx_sync2 == STOP_LEVEL) begin
                            r_rx_byte <= r_rx_shift;
                            r_rx_dv   <= 1'b1;
                        end
                        r_rx_state <= S_CLEANUP;
                    end
                end
                S_CLEANUP: begin
                    r_rx_state <= S_IDLE;
                end
                default: begin
                    r_rx_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV   = r_rx_dv;
    assign o_Rx_Byte = r_rx_byte;

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: table-driven TX/RX frames with queue scoreboards,
// plus hand-written sequences for held request, back-to-back, glitch, framing error and reset.
module tb_uart_txrx;

    localparam int unsigned CPB = 87;

    logic       i_Clock = 1'b0;
    logic       i_Reset;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         period;
        int         start_len;
        int         stop_len;
        logic       exp_dv;
        logic [7:0] exp_byte;
    } rx_vec_t;

    rx_vec_t    rx_vecs [6];
    logic [7:0] tx_vecs [5];

    uart_txrx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Tx_DV     (i_Tx_DV),
        .i_Tx_Byte   (i_Tx_Byte),
        .o_Tx_Active (o_Tx_Active),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Done   (o_Tx_Done),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Byte   (o_Rx_Byte)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic wait_tx_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge i_Clock);
            n++;
        end while (o_Tx_Done !== 1'b1 && n < 12 * CPB);
        check(name, 32'(o_Tx_Done), 32'd1);
    endtask

    task automatic tx_send(input logic [7:0] b);
        tick();
        i_Tx_Byte = b;
        i_Tx_DV   = 1'b1;
        tx_q.push_back(b);
        tick();
        i_Tx_DV   = 1'b0;
        i_Tx_Byte = ~b;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop, input int period,
                           input int start_len, input int stop_len);
        tick();
        i_Rx_Serial = 1'b0;
        repeat (start_len) tick();
        for (int b = 0; b < 8; b++) begin
            i_Rx_Serial = d[b];
            repeat (period) tick();
        end
        i_Rx_Serial = stop;
        repeat (stop_len) tick();
        i_Rx_Serial = 1'b1;
    endtask

    always @(negedge i_Clock) begin
        if (o_Tx_Done === 1'b1) done_cnt++;
    end

    // RX scoreboard: every DV must match the oldest expected byte.
    always @(negedge i_Clock) begin
        if (o_Rx_DV === 1'b1) begin
            check("rx_dv_expected", 32'(rx_q.size() > 0), 32'd1);
            if (rx_q.size() > 0) check("rx_byte", 32'(o_Rx_Byte), 32'(rx_q.pop_front()));
        end
    end

    // TX scoreboard: decode the line at mid-bit and compare against the oldest request.
    initial begin : tx_mon
        logic       prev;
        logic       aborted;
        logic [9:0] bits;
        logic [7:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge i_Clock);
            if (prev === 1'b1 && o_Tx_Serial === 1'b0 && i_Reset === 1'b0) begin
                aborted = 1'b0;
                bits    = '0;
                for (int c = 1; c <= int'(9 * CPB + CPB / 2); c++) begin
                    @(negedge i_Clock);
                    if (i_Reset === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % CPB == CPB / 2) bits[c / CPB] = o_Tx_Serial;
                end
                check("tx_frame_expected", 32'(tx_q.size() > 0), 32'd1);
                if (tx_q.size() > 0) begin
                    exp = tx_q.pop_front();
                    if (!aborted) begin
                        check("tx_start_bit", 32'(bits[0]), 32'd0);
                        check("tx_data", 32'(bits[8:1]), 32'(exp));
                        check("tx_stop_bit", 32'(bits[9]), 32'd1);
                    end
                end
            end
            prev = o_Tx_Serial;
        end
    end

    initial begin
        repeat (100000) @(posedge i_Clock);
        $display("FAIL watchdog: cycles=100000 expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] ab_bits;
        int         bad [10];
        int         act_bad;
        int         d0;

        rx_vecs[0] = '{8'h3F, 1'b1, 86, 96, 86, 1'b1, 8'h3F};
        rx_vecs[1] = '{8'h55, 1'b0, 87, 87, 50, 1'b0, 8'h3F};
        rx_vecs[2] = '{8'hA5, 1'b1, 87, 87, 87, 1'b1, 8'hA5};
        rx_vecs[3] = '{8'h00, 1'b1, 90, 90, 90, 1'b1, 8'h00};
        rx_vecs[4] = '{8'hFF, 1'b1, 84, 84, 84, 1'b1, 8'hFF};
        rx_vecs[5] = '{8'h81, 1'b1, 87, 87, 87, 1'b1, 8'h81};
        tx_vecs    = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'hC3};

        i_Reset     = 1'b1;
        i_Tx_DV     = 1'b0;
        i_Tx_Byte   = 8'h00;
        i_Rx_Serial = 1'b1;
        repeat (3) tick();
        @(negedge i_Clock);
        check("rst_tx_serial", 32'(o_Tx_Serial), 32'd1);
        check("rst_tx_active", 32'(o_Tx_Active), 32'd0);
        check("rst_tx_done",   32'(o_Tx_Done),   32'd0);
        check("rst_rx_dv",     32'(o_Rx_DV),     32'd0);
        check("rst_rx_byte",   32'(o_Rx_Byte),   32'h00);
        tick();
        i_Reset = 1'b0;
        repeat (5) tick();

        // 0xAB with the request held for a full bit: exactly one frame.
        ab_bits = {1'b1, 8'hAB, 1'b0};
        act_bad = 0;
        for (int b = 0; b < 10; b++) bad[b] = 0;
        d0 = done_cnt;
        tick();
        i_Tx_Byte = 8'hAB;
        i_Tx_DV   = 1'b1;
        tx_q.push_back(8'hAB);
        @(posedge i_Clock);
        for (int i = 0; i < int'(10 * CPB); i++) begin
            @(negedge i_Clock);
            if (o_Tx_Serial !== ab_bits[i / CPB]) bad[i / CPB]++;
            if (o_Tx_Active !== 1'b1) act_bad++;
            if (i == int'(CPB) - 1) begin
                i_Tx_DV   = 1'b0;
                i_Tx_Byte = 8'h00;
            end
        end
        for (int b = 0; b < 10; b++) check($sformatf("ab_bit%0d_bad_cycles", b), 32'(bad[b]), 32'd0);
        check("ab_active_bad_cycles", 32'(act_bad), 32'd0);
        @(negedge i_Clock);
        check("ab_done_pulse", 32'(o_Tx_Done), 32'd1);
        check("ab_active_cleanup", 32'(o_Tx_Active), 32'd0);
        @(negedge i_Clock);
        check("ab_done_one_cycle", 32'(o_Tx_Done), 32'd0);
        repeat (300) @(negedge i_Clock);
        check("ab_single_done", 32'(done_cnt - d0), 32'd1);
        check("ab_no_second_frame", 32'(o_Tx_Active), 32'd0);

        // Back-to-back: second request lands on the idle cycle right after Done.
        tx_send(8'h5A);
        wait_tx_done("b2b_first_done");
        @(posedge i_Clock);
        #1;
        i_Tx_Byte = 8'h00;
        i_Tx_DV   = 1'b1;
        tx_q.push_back(8'h00);
        tick();
        i_Tx_DV = 1'b0;
        @(negedge i_Clock);
        check("b2b_active", 32'(o_Tx_Active), 32'd1);
        check("b2b_start_bit", 32'(o_Tx_Serial), 32'd0);
        wait_tx_done("b2b_second_done");
        repeat (5) tick();

        // Full duplex: TX table and RX table run concurrently.
        fork
            begin
                for (int v = 0; v < 5; v++) begin
                    d0 = done_cnt;
                    tx_send(tx_vecs[v]);
                    wait_tx_done($sformatf("tx_vec%0d_done", v));
                    repeat (3) @(negedge i_Clock);
                    check($sformatf("tx_vec%0d_done_count", v), 32'(done_cnt - d0), 32'd1);
                    repeat (5) tick();
                end
            end
            begin
                for (int v = 0; v < 6; v++) begin
                    if (rx_vecs[v].exp_dv) rx_q.push_back(rx_vecs[v].data);
                    rx_send(rx_vecs[v].data, rx_vecs[v].stop, rx_vecs[v].period,
                            rx_vecs[v].start_len, rx_vecs[v].stop_len);
                    @(negedge i_Clock);
                    check($sformatf("rx_vec%0d_byte_hold", v), 32'(o_Rx_Byte), 32'(rx_vecs[v].exp_byte));
                    repeat (2 * CPB) tick();
                    check($sformatf("rx_vec%0d_consumed", v), 32'(rx_q.size()), 32'd0);
                end
                tick();
                i_Rx_Serial = 1'b0;
                repeat (20) tick();
                i_Rx_Serial = 1'b1;
                repeat (3 * CPB) tick();
                check("rx_glitch_byte", 32'(o_Rx_Byte), 32'h81);
                check("rx_glitch_no_dv", 32'(rx_q.size()), 32'd0);
            end
        join

        // Reset in the middle of TX bit 4 and RX bit 4.
        repeat (20) tick();
        d0 = done_cnt;
        i_Tx_Byte   = 8'hC3;
        i_Tx_DV     = 1'b1;
        tx_q.push_back(8'hC3);
        i_Rx_Serial = 1'b0;
        tick();
        i_Tx_DV = 1'b0;
        repeat (5 * CPB + 40) tick();
        check("rst_mid_active_before", 32'(o_Tx_Active), 32'd1);
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        @(posedge i_Clock);
        @(negedge i_Clock);
        check("rst_mid_tx_serial", 32'(o_Tx_Serial), 32'd1);
        check("rst_mid_tx_active", 32'(o_Tx_Active), 32'd0);
        check("rst_mid_tx_done",   32'(o_Tx_Done),   32'd0);
        check("rst_mid_rx_dv",     32'(o_Rx_DV),     32'd0);
        tick();
        i_Reset = 1'b0;
        repeat (20 * CPB) tick();
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_rx_byte", 32'(o_Rx_Byte), 32'h00);
        check("rst_mid_idle_line", 32'(o_Tx_Serial), 32'd1);
        check("final_tx_queue", 32'(tx_q.size()), 32'd0);
        check("final_rx_queue", 32'(rx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
